// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder.
// Adds num1 + num2 + c_in one bit per clock through a single full-adder cell.
// A start/busy/done handshake connects it to the control unit. Subtraction is
// num1 + ~num2 with c_in = 1.
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN. When it is defined,
// overflow is the registered signed-overflow flag. When it is undefined,
// overflow is tied to 0.
// FSM state is visible through busy (RUN) and done (DONE); both low means IDLE.
// Handshake: start is sampled on a rising edge only in IDLE or DONE. The edge
// that samples it captures num1/num2/c_in. busy is high for the WIDTH
// processing cycles. done is high for exactly the one cycle in which the new
// result/c_out/overflow are first visible.
`timescale 1ns/1ps

module serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_q;
    logic             c_out_q;

    logic             s_bit;
    logic             cy_next;
    logic [WIDTH:0]   sum_next;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             overflow_q;
`endif

    // Full-adder cell on the current LSBs, plus the shifted-in sum vector.
    // sum_next[WIDTH:1] is the next s_sr. On the MSB cycle it is also the
    // final result.
    always_comb begin
        s_bit    = a_sr[0] ^ b_sr[0] ^ cy;
        cy_next  = (a_sr[0] & b_sr[0]) | (a_sr[0] & cy) | (b_sr[0] & cy);
        sum_next = {s_bit, s_sr};
    end

    // Control FSM and datapath. The outputs move only on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            s_sr     <= '0;
            cy       <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= num1;
                        b_sr  <= num2;
                        cy    <= c_in;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    s_sr <= sum_next[WIDTH:1];
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    cy   <= cy_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        result_q <= sum_next[WIDTH:1];
                        c_out_q  <= cy_next;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // The carry into the MSB is the carry still held in cy.
                        overflow_q <= cy ^ cy_next;
`endif
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign result = result_q;
    assign c_out  = c_out_q;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
